// File: rtl/mips_multicycle_ctrl_if.sv
// Datapath control bus for the multi-cycle MIPS controller.
// Carries the instruction opcode and memory handshake into the controller,
// and every datapath strobe/select from the controller to the datapath.
//   master : controller side (drives strobes, receives opcode/mem_ready)
//   slave  : datapath side (drives opcode/mem_ready, receives strobes)
interface mips_multicycle_ctrl_if #(
  parameter int OPC_W = 6
);
  logic [OPC_W-1:0] opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Control FSM for a multi-cycle MIPS datapath (R-type, lw, sw, beq, j, addi).
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset (returns to FETCH)
//   bus      : control bus (master) - opcode/mem_ready in, datapath strobes out
//   state    : current state encoding (debug)
//   halted   : high while parked in HALT after an illegal opcode
//   retired  : instructions completed since reset (wraps)
module mips_multicycle_ctrl #(
  parameter int RETIRE_W = 32,
  parameter int OPC_W    = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mips_multicycle_ctrl_if.master bus,
  output logic [3:0]           state,
  output logic                 halted,
  output logic [RETIRE_W-1:0]  retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  // Registered strobe set. fetch/jump are kept separately so ir_write and
  // pc_write can be qualified by mem_ready after the register.
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write_cond;
    logic       fetch;
    logic       jump;
    logic       halted;
  } strobe_t;

  localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);
  localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'b000010);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'b001000);

  // Strobes that are active while the FSM sits in state s.
  function automatic strobe_t decode_strobes(state_t s);
    strobe_t o;
    o = '0;
    case (s)
      S_FETCH: begin
        o.mem_read  = 1'b1;
        o.alu_src_b = 2'b01;
        o.fetch     = 1'b1;
      end
      S_DECODE:   o.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        o.mem_read = 1'b1;
        o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        o.mem_write = 1'b1;
        o.iord      = 1'b1;
      end
      S_EXEC: begin
        o.alu_src_a = 1'b1;
        o.alu_op    = 2'b10;
      end
      S_R_WB: begin
        o.reg_write = 1'b1;
        o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o.alu_src_a     = 1'b1;
        o.alu_op        = 2'b01;
        o.pc_write_cond = 1'b1;
        o.pc_source     = 2'b01;
      end
      S_JUMP: begin
        o.jump      = 1'b1;
        o.pc_source = 2'b10;
      end
      S_ADDI_EX: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = 2'b10;
      end
      S_ADDI_WB:  o.reg_write = 1'b1;
      S_HALT:     o.halted    = 1'b1;
      default:    o = '0;
    endcase
    return o;
  endfunction

  state_t  cur;
  state_t  nxt;
  strobe_t str;
  logic    retire;

  always_comb begin
    nxt    = S_HALT;
    retire = 1'b0;
    case (cur)
      S_FETCH:    nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (bus.opcode == OP_LW || bus.opcode == OP_SW) nxt = S_MEM_ADDR;
        else if (bus.opcode == OP_RTYPE)                nxt = S_EXEC;
        else if (bus.opcode == OP_BEQ)                  nxt = S_BRANCH;
        else if (bus.opcode == OP_J)                    nxt = S_JUMP;
        else if (bus.opcode == OP_ADDI)                 nxt = S_ADDI_EX;
        else                                            nxt = S_HALT;
      end
      S_MEM_ADDR: nxt = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   nxt = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      // The store completes on the handshake cycle, so it retires there.
      S_MEM_WR: begin
        nxt    = bus.mem_ready ? S_FETCH : S_MEM_WR;
        retire = bus.mem_ready;
      end
      S_EXEC:     nxt = S_R_WB;
      S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_ADDI_EX:  nxt = S_ADDI_WB;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_HALT;
    endcase
  end

  // Strobes are registered from the next state so they are glitch-free and
  // coincide with the state they belong to; reset loads FETCH's set directly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur     <= S_FETCH;
      str     <= decode_strobes(S_FETCH);
      retired <= '0;
    end else begin
      cur <= nxt;
      str <= decode_strobes(nxt);
      if (retire) retired <= retired + RETIRE_W'(1);
    end
  end

  assign state             = cur;
  assign halted            = str.halted;
  assign bus.iord          = str.iord;
  assign bus.mem_read      = str.mem_read;
  assign bus.mem_write     = str.mem_write;
  assign bus.mem_to_reg    = str.mem_to_reg;
  assign bus.reg_dst       = str.reg_dst;
  assign bus.reg_write     = str.reg_write;
  assign bus.alu_src_a     = str.alu_src_a;
  assign bus.alu_src_b     = str.alu_src_b;
  assign bus.alu_op        = str.alu_op;
  assign bus.pc_source     = str.pc_source;
  assign bus.pc_write_cond = str.pc_write_cond;
  // Only the fetch handshake gates strobes combinationally.
  assign bus.ir_write      = str.fetch & bus.mem_ready;
  assign bus.pc_write      = str.jump | (str.fetch & bus.mem_ready);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  state, state4;
  logic        halted, halted4;
  logic [31:0] retired;
  logic [3:0]  retired4;

  always #5 clock = ~clock;

  mips_multicycle_ctrl_if bus();
  mips_multicycle_ctrl_if bus4();

  mips_multicycle_ctrl #(.RETIRE_W(32), .OPC_W(6)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .state(state), .halted(halted), .retired(retired)
  );

  mips_multicycle_ctrl #(.RETIRE_W(4), .OPC_W(6)) dut4 (
    .clock(clock), .reset_n(reset_n), .bus(bus4),
    .state(state4), .halted(halted4), .retired(retired4)
  );

  assign bus4.opcode    = bus.opcode;
  assign bus4.mem_ready = bus.mem_ready;

  wire [16:0] got = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
                     bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                     bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                     bus.pc_source, halted};

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                         OP_BAD = 6'b111111;

  int checks = 0;
  int errors = 0;

  // Reference model: current step of the running instruction plus the list
  // of steps still to come, chosen per instruction class at decode.
  int          m_cur;
  int          plan[$];
  logic [31:0] m_ret;

  function automatic void set_plan(logic [5:0] op);
    plan.delete();
    case (op)
      OP_LW:   plan = '{2, 3, 4};
      OP_SW:   plan = '{2, 5};
      OP_R:    plan = '{6, 7};
      OP_BEQ:  plan = '{8};
      OP_J:    plan = '{9};
      OP_ADDI: plan = '{10, 11};
      default: plan = '{12};
    endcase
  endfunction

  function automatic void model_reset();
    m_cur = 0;
    plan.delete();
    m_ret = '0;
  endfunction

  function automatic void model_step(logic [5:0] op, logic rdy);
    bit waits;
    waits = (m_cur == 0 || m_cur == 3 || m_cur == 5) && !rdy;
    if (m_cur == 12 || waits) return;
    if (m_cur == 0) m_cur = 1;
    else if (m_cur == 1) begin
      set_plan(op);
      m_cur = plan.pop_front();
    end else if (plan.size() > 0) m_cur = plan.pop_front();
    else begin
      m_ret = m_ret + 1;
      m_cur = 0;
    end
  endfunction

  // Expected strobes for a step, listed field by field from the step's role.
  function automatic logic [16:0] exp_vec(int st, logic rdy);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, hlt;
    logic [1:0] sb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, hlt} = '0;
    sb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      0:  begin mrd = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin sa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      9:  begin pcw = 1; psrc = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      12: hlt = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, psrc, hlt};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Called at posedge+1; checks at negedge, advances the model at posedge.
  task automatic cycle();
    @(negedge clock);
    chk("state", 64'(state), 64'(m_cur));
    chk("strobes", 64'(got), 64'(exp_vec(m_cur, bus.mem_ready)));
    chk("retired", 64'(retired), 64'(m_ret));
    chk("state_w4", 64'(state4), 64'(m_cur));
    chk("retired_w4", 64'(retired4), 64'(m_ret[3:0]));
    @(posedge clock);
    model_step(bus.opcode, bus.mem_ready);
    #1;
  endtask

  // Called at posedge+1; asserts reset away from the edge, checks the
  // asynchronous effect, releases at the next posedge+1.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_strobes", 64'(got), 64'(exp_vec(0, bus.mem_ready)));
    chk("reset_retired", 64'(retired), 64'd0);
    chk("reset_halted", 64'(halted), 64'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    logic [5:0] opc;
    int         exp_state;  // state entered after DECODE
    int         exp_cpi;    // cycles to retire with mem_ready high, 0 = never
  } vec_t;

  vec_t vecs[7];
  int   n;
  logic [5:0] legal_ops[6];

  initial begin
    vecs[0] = '{OP_R,    6,  4};
    vecs[1] = '{OP_LW,   2,  5};
    vecs[2] = '{OP_SW,   2,  4};
    vecs[3] = '{OP_ADDI, 10, 4};
    vecs[4] = '{OP_BEQ,  8,  3};
    vecs[5] = '{OP_J,    9,  3};
    vecs[6] = '{OP_BAD,  12, 0};
    legal_ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

    reset_n       = 1'b0;
    bus.opcode    = OP_R;
    bus.mem_ready = 1'b1;
    model_reset();
    @(posedge clock);
    #1;

    // Table: decode target and CPI per instruction class.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      bus.opcode    = vecs[i].opc;
      bus.mem_ready = 1'b1;
      cycle();
      cycle();
      chk("decode_target", 64'(state), 64'(vecs[i].exp_state));
      n = 2;
      while (retired == 0 && n < 20 && vecs[i].exp_cpi != 0) begin
        cycle();
        n++;
      end
      if (vecs[i].exp_cpi != 0) chk("cpi", 64'(n), 64'(vecs[i].exp_cpi));
    end

    // lw stalled three cycles in MEM_RD: eight cycles in all.
    do_reset();
    bus.opcode    = OP_LW;
    bus.mem_ready = 1'b1;
    n = 0;
    while (state != 4'd3 && n < 10) begin cycle(); n++; end
    bus.mem_ready = 1'b0;
    repeat (3) begin cycle(); n++; end
    bus.mem_ready = 1'b1;
    while (retired == 0 && n < 20) begin cycle(); n++; end
    chk("lw_stall_cycles", 64'(n), 64'd8);

    // sw stalled two cycles in MEM_WR: retires on the handshake cycle.
    do_reset();
    bus.opcode = OP_SW;
    n = 0;
    while (state != 4'd5 && n < 10) begin cycle(); n++; end
    bus.mem_ready = 1'b0;
    repeat (2) begin cycle(); n++; end
    bus.mem_ready = 1'b1;
    while (retired == 0 && n < 20) begin cycle(); n++; end
    chk("sw_stall_cycles", 64'(n), 64'd6);

    // Illegal opcode parks in HALT regardless of mem_ready.
    do_reset();
    bus.opcode = OP_BAD;
    repeat (2) cycle();
    repeat (20) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    chk("halt_state", 64'(state), 64'd12);
    bus.mem_ready = 1'b1;

    // FETCH stall, then lw stalled in MEM_RD interrupted by async reset.
    do_reset();
    bus.opcode    = OP_LW;
    bus.mem_ready = 1'b0;
    repeat (5) cycle();
    bus.mem_ready = 1'b1;
    n = 0;
    while (state != 4'd3 && n < 10) begin cycle(); n++; end
    bus.mem_ready = 1'b0;
    repeat (2) cycle();
    chk("stall_before_reset", 64'(state), 64'd3);
    do_reset();
    bus.mem_ready = 1'b1;

    // Sixteen R-types wrap the 4-bit counter.
    do_reset();
    bus.opcode = OP_R;
    repeat (64) cycle();
    chk("wrap_w4", 64'(retired4), 64'd0);
    chk("wrap_w32", 64'(retired), 64'd16);

    // Random instruction mix with random memory latency.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (m_cur == 0) begin
        if ($urandom_range(0, 40) == 0) bus.opcode = 6'($urandom);
        else bus.opcode = legal_ops[$urandom_range(0, 5)];
      end
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (m_cur == 12 && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
